// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared definitions for the iterative divider
// FSM encoding, parameter legality check and EX-stage div_op codes.
package div_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_CALC = 3'b010,
      ST_DONE = 3'b100
   } div_state_e;

   localparam int DIV_MIN_WIDTH = 4;

   function automatic bit div_cfg_ok(input int width, input int unroll);
      return (width >= DIV_MIN_WIDTH) && ((width % 2) == 0) &&
             ((unroll == 1) || (unroll == 2) || (unroll == 4)) &&
             ((width % unroll) == 0);
   endfunction

   // Shared with EX decode: bit 1 set selects the unsigned variants.
   localparam logic [1:0] DIV_OP_DIV_W  = 2'd0;
   localparam logic [1:0] DIV_OP_MOD_W  = 2'd1;
   localparam logic [1:0] DIV_OP_DIV_WU = 2'd2;
   localparam logic [1:0] DIV_OP_MOD_WU = 2'd3;

   function automatic logic div_op_is_signed(input logic [1:0] op);
      return ~op[1];
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division step
// Shifts {rem, dvd} left, trial-subtracts the divisor and shifts the quotient bit in.
module div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   i_rem,
   input  logic [W-1:0] i_dvd,
   input  logic [W-1:0] i_dsr,
   output logic [W:0]   o_rem,
   output logic [W-1:0] o_dvd
);

   logic [W:0] w_shift_rem;
   logic [W:0] w_diff;
   logic       w_borrow;

   // Partial remainder stays below the divisor, so the shifted value fits W+1 bits
   assign w_shift_rem = {i_rem[W-1:0], i_dvd[W-1]};
   assign w_diff      = w_shift_rem - {1'b0, i_dsr};
   assign w_borrow    = w_diff[W];

   assign o_rem = w_borrow ? w_shift_rem : w_diff;
   assign o_dvd = {i_dvd[W-2:0], ~w_borrow};

endmodule

// File: rtl/iter_div.sv
// rtl/iter_div.sv - radix-2^UNROLL restoring divider, signed/unsigned, valid/ready
// Produces quotient (toward zero) and remainder (sign of dividend) together.
module iter_div
   import div_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);

   if (!div_cfg_ok(WIDTH, UNROLL)) begin : g_bad_cfg
      $error("iter_div: unsupported WIDTH/UNROLL combination");
   end

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dsr;
   logic [CW-1:0]    r_cnt;
   logic             r_q_neg;
   logic             r_r_neg;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic             w_accept;
   logic             w_dsr_zero;
   logic             w_last;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dsr_mag;
   logic [WIDTH-1:0] w_q_mag;
   logic [WIDTH-1:0] w_r_mag;

   logic [WIDTH:0]   w_rem_chain [0:UNROLL];
   logic [WIDTH-1:0] w_dvd_chain [0:UNROLL];

   assign w_accept   = (r_state == ST_IDLE) && in_valid && !flush;
   assign w_dsr_zero = (divisor == '0);
   assign w_last     = (r_cnt == CW'(1));

   // Most-negative operand negates to itself, which is the correct unsigned magnitude
   assign w_dvd_mag = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign w_dsr_mag = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   assign w_rem_chain[0] = r_rem;
   assign w_dvd_chain[0] = r_dvd;

   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      div_step #(.W(WIDTH)) u_step (
         .i_rem (w_rem_chain[g]),
         .i_dvd (w_dvd_chain[g]),
         .i_dsr (r_dsr),
         .o_rem (w_rem_chain[g+1]),
         .o_dvd (w_dvd_chain[g+1])
      );
   end

   assign w_q_mag = w_dvd_chain[UNROLL];
   assign w_r_mag = w_rem_chain[UNROLL][WIDTH-1:0];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = w_dsr_zero ? ST_DONE : ST_CALC;
         ST_CALC: if (w_last)   w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem       <= '0;
         r_dvd       <= '0;
         r_dsr       <= '0;
         r_cnt       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else if (w_accept) begin
         r_rem   <= '0;
         r_dvd   <= w_dvd_mag;
         r_dsr   <= w_dsr_mag;
         r_cnt   <= CW'(N);
         r_q_neg <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         r_r_neg <= in_signed && dividend[WIDTH-1];
         if (w_dsr_zero) begin
            r_quotient  <= '1;
            r_remainder <= dividend;
            r_dbz       <= 1'b1;
         end
      end else if ((r_state == ST_CALC) && !flush) begin
         r_rem <= w_rem_chain[UNROLL];
         r_dvd <= w_dvd_chain[UNROLL];
         r_cnt <= r_cnt - 1'b1;
         if (w_last) begin
            r_quotient  <= r_q_neg ? -w_q_mag : w_q_mag;
            r_remainder <= r_r_neg ? -w_r_mag : w_r_mag;
            r_dbz       <= 1'b0;
         end
      end
   end

   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = (r_state == ST_DONE);
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule
